// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the RAM, and mem_arbiter.
// master = requesters and RAM side; slave = the arbiter.
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dhit;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        memerr;

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first.
// Define MEM_ARBITER_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT data hits.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic         CLK,
   input logic         nRST,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } state_t;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   state_t      state, next_state;
   logic        dreq;
   logic        starve;
   logic        ihit_c, dhit_c, err_c;
   logic        ren_c, wen_c;
   logic [31:0] iload_c, dload_c, addr_c, store_c;

   assign dreq = bus.dREN | bus.dWEN;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0] dcnt;

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v >= LIMIT) ? LIMIT : v + 3'd1;
   endfunction

   always_ff @(posedge CLK) begin
      if (!nRST)
         dcnt <= 3'd0;
      else if (ihit_c)
         dcnt <= 3'd0;
      else if (dhit_c)
         dcnt <= sat_inc(dcnt);
   end

   assign starve = bus.iREN && (dcnt == LIMIT);
`else
   logic [31:0] unused_limit;
   assign unused_limit = 32'(STARVE_LIMIT);
   assign starve       = 1'b0;
`endif

   // Grant decision and RAM-side drive, combinational from state and the owner's request
   always_comb begin
      next_state = state;
      ihit_c     = 1'b0;
      dhit_c     = 1'b0;
      err_c      = 1'b0;
      ren_c      = 1'b0;
      wen_c      = 1'b0;
      iload_c    = 32'd0;
      dload_c    = 32'd0;
      addr_c     = 32'd0;
      store_c    = 32'd0;
      case (state)
         IDLE: begin
            if (starve)
               next_state = IGNT;
            else if (dreq)
               next_state = DGNT;
            else if (bus.iREN)
               next_state = IGNT;
         end
         IGNT: begin
            addr_c = bus.iaddr;
            ren_c  = bus.iREN;
            if (!bus.iREN) begin
               next_state = IDLE;
            end else if (bus.ramstate == RS_ACCESS) begin
               ihit_c     = 1'b1;
               iload_c    = bus.ramload;
               next_state = IDLE;
            end else if (bus.ramstate == RS_ERROR) begin
               err_c      = 1'b1;
               next_state = IDLE;
            end
         end
         DGNT: begin
            addr_c  = bus.daddr;
            store_c = bus.dstore;
            wen_c   = bus.dWEN;
            ren_c   = bus.dREN & ~bus.dWEN;
            if (!dreq) begin
               next_state = IDLE;
            end else if (bus.ramstate == RS_ACCESS) begin
               dhit_c     = 1'b1;
               dload_c    = bus.dWEN ? 32'd0 : bus.ramload;
               next_state = IDLE;
            end else if (bus.ramstate == RS_ERROR) begin
               err_c      = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST)
         state <= IDLE;
      else
         state <= next_state;
   end

   assign bus.ihit     = ihit_c;
   assign bus.iload    = iload_c;
   assign bus.dhit     = dhit_c;
   assign bus.dload    = dload_c;
   assign bus.ramREN   = ren_c;
   assign bus.ramWEN   = wen_c;
   assign bus.ramaddr  = addr_c;
   assign bus.ramstore = store_c;
   assign bus.memerr   = err_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a cycle-level ownership model of the arbitration rules.
module tb_mem_arbiter;

   localparam int LIM = 4;

   logic CLK;
   logic nRST;
   int   checks;
   int   failures;

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [132:0] outv();
      return {bus.ihit, bus.iload, bus.dhit, bus.dload, bus.ramREN, bus.ramWEN,
              bus.ramaddr, bus.ramstore, bus.memerr};
   endfunction

   function automatic logic [132:0] mk(input logic ih, input logic [31:0] il,
                                       input logic dh, input logic [31:0] dl,
                                       input logic rr, input logic rw,
                                       input logic [31:0] ra, input logic [31:0] rs,
                                       input logic me);
      return {ih, il, dh, dl, rr, rw, ra, rs, me};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
   endtask

   task automatic go_idle();
      tick();
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_reset();
      logic [132:0] e;
      nRST = 0;
      clear_inputs();
      bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h10; bus.daddr = 32'h20;
      bus.ramstate = 2'd2; bus.ramload = 32'h5555_AAAA;
      tick();
      tick();
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=%h", outv(), e);
      end
      tick();
      nRST = 1;
      clear_inputs();
      #3;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", outv(), e);
      end
      go_idle();
   endtask

   task automatic test_ifetch();
      logic [132:0] e;
      tick();
      bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'd0;
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL ifetch_request_cycle got=%h exp=%h", outv(), e);
      end
      tick();
      bus.ramstate = 2'd2; bus.ramload = 32'h2002_000A;
      #3;
      e = mk(1, 32'h2002_000A, 0, 0, 1, 0, 32'h40, 0, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL ifetch_hit got=%h exp=%h", outv(), e);
      end
      tick();
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL ifetch_back_to_idle got=%h exp=%h", outv(), e);
      end
      go_idle();
   endtask

   task automatic test_priority();
      logic [132:0] e;
      tick();
      bus.iREN = 1; bus.iaddr = 32'h80;
      bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD;
      bus.ramstate = 2'd0;
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL prio_request_cycle got=%h exp=%h", outv(), e);
      end
      tick();
      bus.ramstate = 2'd1;
      #3;
      e = mk(0, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL prio_data_granted got=%h exp=%h", outv(), e);
      end
      tick();
      bus.ramstate = 2'd2; bus.ramload = 32'h1111_1111;
      #3;
      e = mk(0, 0, 1, 0, 0, 1, 32'h100, 32'hDEAD, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL prio_write_hit got=%h exp=%h", outv(), e);
      end
      tick();
      bus.dREN = 0; bus.dWEN = 0; bus.ramstate = 2'd0;
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL prio_idle_between got=%h exp=%h", outv(), e);
      end
      tick();
      bus.ramstate = 2'd2; bus.ramload = 32'h0000_0033;
      #3;
      e = mk(1, 32'h33, 0, 0, 1, 0, 32'h80, 0, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL prio_fetch_after_data got=%h exp=%h", outv(), e);
      end
      go_idle();
   endtask

   task automatic test_busy_wait();
      logic [132:0] e;
      int dhits;
      dhits = 0;
      tick();
      bus.dREN = 1; bus.daddr = 32'h200; bus.ramstate = 2'd1;
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL busy_request_cycle got=%h exp=%h", outv(), e);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         #3;
         if (bus.dhit === 1'b1) dhits++;
         e = mk(0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
         checks++;
         if (outv() !== e) begin
            failures++;
            $display("FAIL busy_wait_%0d got=%h exp=%h", k, outv(), e);
         end
      end
      tick();
      bus.ramstate = 2'd2; bus.ramload = 32'h1234_5678;
      #3;
      if (bus.dhit === 1'b1) dhits++;
      e = mk(0, 0, 1, 32'h1234_5678, 1, 0, 32'h200, 0, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL busy_read_hit got=%h exp=%h", outv(), e);
      end
      tick();
      bus.dREN = 0; bus.ramstate = 2'd0;
      #3;
      if (bus.dhit === 1'b1) dhits++;
      checks++;
      if (dhits !== 1) begin
         failures++;
         $display("FAIL busy_hit_count got=%0d exp=1", dhits);
      end
      go_idle();
   endtask

   task automatic test_error_retry();
      logic [132:0] e;
      tick();
      bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = 2'd3;
      #3;
      tick();
      #3;
      e = mk(0, 0, 0, 0, 1, 0, 32'h300, 0, 1);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL error_memerr got=%h exp=%h", outv(), e);
      end
      tick();
      bus.ramstate = 2'd0;
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL error_back_to_idle got=%h exp=%h", outv(), e);
      end
      tick();
      #3;
      e = mk(0, 0, 0, 0, 1, 0, 32'h300, 0, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL error_regrant got=%h exp=%h", outv(), e);
      end
      tick();
      bus.ramstate = 2'd2; bus.ramload = 32'hABCD_0123;
      #3;
      e = mk(0, 0, 1, 32'hABCD_0123, 1, 0, 32'h300, 0, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL error_retry_hit got=%h exp=%h", outv(), e);
      end
      go_idle();
   endtask

   task automatic test_reset_midgrant();
      logic [132:0] e;
      tick();
      bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = 2'd1;
      #3;
      tick();
      nRST = 0;
      #3;
      e = mk(0, 0, 0, 0, 1, 0, 32'h400, 0, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL midgrant_before_reset got=%h exp=%h", outv(), e);
      end
      tick();
      nRST = 1; bus.ramstate = 2'd2; bus.ramload = 32'h7777_7777;
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL midgrant_after_reset got=%h exp=%h", outv(), e);
      end
      go_idle();
   endtask

   task automatic test_drop();
      logic [132:0] e;
      tick();
      bus.iREN = 1; bus.iaddr = 32'h600; bus.ramstate = 2'd0;
      #3;
      tick();
      bus.iREN = 0; bus.ramstate = 2'd2; bus.ramload = 32'h9999_9999;
      #3;
      e = mk(0, 0, 0, 0, 0, 0, 32'h600, 0, 0);
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL drop_no_hit got=%h exp=%h", outv(), e);
      end
      tick();
      #3;
      e = '0;
      checks++;
      if (outv() !== e) begin
         failures++;
         $display("FAIL drop_idle got=%h exp=%h", outv(), e);
      end
      go_idle();
   endtask

   task automatic test_starvation();
      int nd, ni, first, second;
      nd = 0; ni = 0; first = -1; second = -1;
      tick();
      nRST = 0;
      clear_inputs();
      tick();
      nRST = 1;
      bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h500; bus.daddr = 32'h600;
      bus.ramstate = 2'd2; bus.ramload = 32'hCAFE_0000;
      for (int c = 0; c < 40; c++) begin
         #3;
         if (bus.dhit === 1'b1) nd++;
         if (bus.ihit === 1'b1) begin
            ni++;
            if (ni == 1) first = nd;
            else if (ni == 2) second = nd - first;
         end
         tick();
      end
`ifdef MEM_ARBITER_STARVE_GUARD_EN
      checks++;
      if (first !== LIM) begin
         failures++;
         $display("FAIL starve_first_fetch dhits_before=%0d exp=%0d", first, LIM);
      end
      checks++;
      if (second !== LIM) begin
         failures++;
         $display("FAIL starve_second_fetch dhits_between=%0d exp=%0d", second, LIM);
      end
`else
      checks++;
      if (ni !== 0) begin
         failures++;
         $display("FAIL starve_no_guard ihits=%0d exp=0", ni);
      end
      checks++;
      if (nd !== 20) begin
         failures++;
         $display("FAIL starve_no_guard_dhits dhits=%0d exp=20", nd);
      end
`endif
      go_idle();
   endtask

   task automatic test_random();
      int owner;           // who holds the RAM: 0 nobody, 1 fetch, 2 data
      int nxt;
      int dsince;          // data hits since last fetch hit, saturating
      int r;
      logic ih, dh, rr, rw, me, dreq;
      logic [31:0] il, dl, ra, rs;
      logic [132:0] e;
      tick();
      nRST = 0;
      clear_inputs();
      tick();
      nRST = 1;
      owner = 0;
      dsince = 0;
      for (int c = 0; c < 400; c++) begin
         bus.iREN    = ($urandom_range(0, 9) < 6);
         bus.dREN    = ($urandom_range(0, 9) < 4);
         bus.dWEN    = ($urandom_range(0, 9) < 3);
         bus.iaddr   = $urandom;
         bus.daddr   = $urandom;
         bus.dstore  = $urandom;
         bus.ramload = $urandom;
         r = $urandom_range(0, 9);
         bus.ramstate = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         nRST = ($urandom_range(0, 24) != 0);
         #3;
         ih = 0; dh = 0; rr = 0; rw = 0; me = 0;
         il = 0; dl = 0; ra = 0; rs = 0;
         dreq = bus.dREN | bus.dWEN;
         nxt = owner;
         if (owner == 0) begin
`ifdef MEM_ARBITER_STARVE_GUARD_EN
            if (bus.iREN && dsince == LIM) nxt = 1;
            else if (dreq) nxt = 2;
            else if (bus.iREN) nxt = 1;
`else
            if (dreq) nxt = 2;
            else if (bus.iREN) nxt = 1;
`endif
         end else if (owner == 1) begin
            ra = bus.iaddr;
            rr = bus.iREN;
            if (!bus.iREN) nxt = 0;
            else if (bus.ramstate == 2'd2) begin ih = 1; il = bus.ramload; nxt = 0; end
            else if (bus.ramstate == 2'd3) begin me = 1; nxt = 0; end
         end else begin
            ra = bus.daddr;
            rs = bus.dstore;
            rw = bus.dWEN;
            rr = bus.dREN & ~bus.dWEN;
            if (!dreq) nxt = 0;
            else if (bus.ramstate == 2'd2) begin
               dh = 1;
               dl = bus.dWEN ? 32'd0 : bus.ramload;
               nxt = 0;
            end else if (bus.ramstate == 2'd3) begin me = 1; nxt = 0; end
         end
         e = mk(ih, il, dh, dl, rr, rw, ra, rs, me);
         checks++;
         if (outv() !== e) begin
            failures++;
            $display("FAIL random_cycle_%0d got=%h exp=%h", c, outv(), e);
         end
         checks++;
         if ((bus.ihit & bus.dhit) !== 1'b0 || (bus.ramREN & bus.ramWEN) !== 1'b0) begin
            failures++;
            $display("FAIL random_exclusive_%0d got=%b%b%b%b exp=no_overlap", c,
                     bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN);
         end
         if (!nRST) begin
            owner = 0;
            dsince = 0;
         end else begin
            owner = nxt;
            if (ih) dsince = 0;
            else if (dh && dsince < LIM) dsince++;
         end
         tick();
      end
      nRST = 1;
      go_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      nRST     = 0;
      clear_inputs();
      test_reset();
      test_ifetch();
      test_priority();
      test_busy_wait();
      test_error_retry();
      test_reset_midgrant();
      test_drop();
      test_starvation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
